// File: rtl/feature_extractor.sv
// feature_extractor: streaming Sobel-x 3x3 conv -> optional ReLU -> 2x2/stride-2 max-pool over a raster image.
// Ports:
//   clk                rising-edge clock
//   rst                asynchronous active-low reset
//   start_signal       one-cycle pulse; starts (or restarts) a frame
//   pixel_valid_in     qualifies pixel_in while a frame is active
//   pixel_in           8-bit unsigned pixel, raster order
//   final_result_out   22-bit signed pooled value, held between results
//   final_result_valid final_result_out is new this cycle
//   final_done_signal  one-cycle pulse the cycle after the last pooled result
// Build option: define FEATURE_EXTRACTOR_RELU_EN to clamp negative conv values to 0 before pooling.
module feature_extractor #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_signal,
    input  logic               pixel_valid_in,
    input  logic [7:0]         pixel_in,
    output logic signed [21:0] final_result_out,
    output logic               final_result_valid,
    output logic               final_done_signal
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int PW = (IMG_WIDTH - 2) / 2;
    localparam int PH = (IMG_HEIGHT - 2) / 2;
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] CX_LAST = XW'(2 * PW - 1);
    localparam logic [YW-1:0] CY_LAST = YW'(2 * PH - 1);

    logic [XW-1:0]       x, s1_cx;
    logic [YW-1:0]       y, s1_cy;
    logic                active, s1_valid, last_out;
    logic [7:0]          lb0 [IMG_WIDTH];
    logic [7:0]          lb1 [IMG_WIDTH];
    logic [7:0]          win [3][3];
    logic signed [21:0]  hold;
    logic signed [21:0]  row_max [PW];
    logic                acc, fire;
    logic [XW-2:0]       pc;
    logic signed [21:0]  left_col, right_col, conv, v, hm, pm;

    always_comb begin
        acc       = active && pixel_valid_in && !start_signal;
        left_col  = 22'(win[0][0]) + 22'({win[1][0], 1'b0}) + 22'(win[2][0]);
        right_col = 22'(win[0][2]) + 22'({win[1][2], 1'b0}) + 22'(win[2][2]);
        conv      = left_col - right_col;
`ifdef FEATURE_EXTRACTOR_RELU_EN
        v         = conv[21] ? '0 : conv;
`else
        v         = conv;
`endif
        pc        = s1_cx[XW-1:1];
        // odd conv column closes the horizontal pair; even one just seeds it
        hm        = s1_cx[0] && hold > v ? hold : v;
        pm        = row_max[pc] > hm ? row_max[pc] : hm;
        // an abort discards the window still in flight; odd trailing row/col never pools
        fire      = s1_valid && !(start_signal && active) && s1_cx <= CX_LAST && s1_cy <= CY_LAST;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            lb0[x] <= pixel_in;
            lb1[x] <= lb0[x];
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[x];
            win[1][2] <= lb0[x];
            win[2][2] <= pixel_in;
        end
        if (fire && !s1_cx[0])
            hold <= v;
        if (fire && s1_cx[0] && !s1_cy[0])
            row_max[pc] <= hm;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x                  <= '0;
            y                  <= '0;
            s1_cx              <= '0;
            s1_cy              <= '0;
            active             <= 1'b0;
            s1_valid           <= 1'b0;
            last_out           <= 1'b0;
            final_result_out   <= '0;
            final_result_valid <= 1'b0;
            final_done_signal  <= 1'b0;
        end else begin
            final_done_signal  <= last_out;
            last_out           <= 1'b0;
            final_result_valid <= 1'b0;
            s1_valid           <= 1'b0;
            if (start_signal) begin
                active <= 1'b1;
                x      <= '0;
                y      <= '0;
            end else if (acc) begin
                x <= x == X_LAST ? '0 : x + 1'b1;
                if (x == X_LAST) begin
                    y <= y + 1'b1;
                    if (y == Y_LAST)
                        active <= 1'b0;
                end
                // window is complete once two prior rows and two prior columns exist
                s1_valid <= |x[XW-1:1] && |y[YW-1:1];
                s1_cx    <= x - XW'(2);
                s1_cy    <= y - YW'(2);
            end
            if (fire && s1_cx[0] && s1_cy[0]) begin
                final_result_out   <= pm;
                final_result_valid <= 1'b1;
                last_out           <= s1_cx == CX_LAST && s1_cy == CY_LAST;
            end
        end
    end
endmodule

// File: tb/tb_feature_extractor.sv
// tb_feature_extractor: table-driven frames with a result scoreboard for feature_extractor.
module tb_feature_extractor;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int NR = 225;
`ifdef FEATURE_EXTRACTOR_RELU_EN
    localparam int NEG8X = 0;
`else
    localparam int NEG8X = -64;
`endif

    typedef struct {
        int pat;
        int gap;
        int kind;
        int val;
    } vec_t;

    logic               clk = 0;
    logic               rst;
    logic               start_signal = 0;
    logic               pixel_valid_in = 0;
    logic [7:0]         pixel_in = 0;
    logic signed [21:0] final_result_out;
    logic               final_result_valid;
    logic               final_done_signal;

    int n_cmp = 0, n_fail = 0, got = 0, dones = 0, last_val = 0, cyc = 0, last_vcyc = 0;
    int exp_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    feature_extractor #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk),
        .rst(rst),
        .start_signal(start_signal),
        .pixel_valid_in(pixel_valid_in),
        .pixel_in(pixel_in),
        .final_result_out(final_result_out),
        .final_result_valid(final_result_valid),
        .final_done_signal(final_done_signal)
    );

    function automatic int pix(int p, int x, int y);
        case (p)
            0: return 100 + (x ^ y);
            1: return 128;
            2: return 255 - 8 * x;
            3: return 8 * x;
            default: return x < 16 ? 255 : 0;
        endcase
    endfunction

    function automatic int conv(int p, int cx, int cy);
        int s = 0;
        for (int r = 0; r < 3; r++)
            s += (r == 1 ? 2 : 1) * (pix(p, cx, cy + r) - pix(p, cx + 2, cy + r));
`ifdef FEATURE_EXTRACTOR_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic int model(int p, int i);
        int m = -100000;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                if (conv(p, 2 * (i % 15) + dx, 2 * (i / 15) + dy) > m)
                    m = conv(p, 2 * (i % 15) + dx, 2 * (i / 15) + dy);
        return m;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_signal = 1;
        tick();
        start_signal = 0;
    endtask

    task automatic drive_pixels(input int p, input int gap, input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            pixel_valid_in = 1;
            pixel_in = 8'(pix(p, k % W, k / W));
            tick();
            pixel_valid_in = 0;
            repeat (gap) tick();
        end
    endtask

    task automatic push_exp(input vec_t v);
        for (int i = 0; i < NR; i++)
            exp_q.push_back(v.kind == 0 ? model(v.pat, i) : v.kind == 1 ? v.val : (i % 15 == 7 ? 1020 : 0));
    endtask

    task automatic finish_frame(input string tag);
        for (int i = 0; i < 50 && dones == 0; i++) tick();
        repeat (5) tick();
        check({tag, "_count"}, got, NR);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
        got = 0;
        dones = 0;
    endtask

    initial begin
        vecs[0] = '{pat: 0, gap: 0, kind: 0, val: 0};
        vecs[1] = '{pat: 1, gap: 0, kind: 1, val: 0};
        vecs[2] = '{pat: 2, gap: 0, kind: 1, val: 64};
        vecs[3] = '{pat: 3, gap: 0, kind: 1, val: NEG8X};
        vecs[4] = '{pat: 4, gap: 0, kind: 2, val: 0};
        vecs[5] = '{pat: 0, gap: 1, kind: 0, val: 0};

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (rst) begin
                    if (final_result_valid) begin
                        if (exp_q.size() == 0)
                            check("unexpected_result", 1, 0);
                        else
                            check($sformatf("result[%0d]", got), int'(final_result_out), exp_q.pop_front());
                        last_val = int'(final_result_out);
                        last_vcyc = cyc;
                        got++;
                    end else
                        check("hold_out", int'(final_result_out), last_val);
                    if (final_done_signal) begin
                        dones++;
                        check("done_with_valid", int'(final_result_valid), 0);
                        check("done_delay", cyc - last_vcyc, 1);
                    end
                end
            end
        join_none

        rst = 1;
        #2 rst = 0;
        repeat (3) tick();
        check("reset_out", int'(final_result_out), 0);
        check("reset_valid", int'(final_result_valid), 0);
        check("reset_done", int'(final_done_signal), 0);
        rst = 1;
        tick();

        // pixels before any start must be ignored
        drive_pixels(0, 0, 0, 40);
        repeat (10) tick();
        check("idle_no_output", got, 0);

        for (int t = 0; t < 6; t++) begin
            push_exp(vecs[t]);
            pulse_start();
            drive_pixels(vecs[t].pat, vecs[t].gap, 0, W * H);
            finish_frame($sformatf("vec%0d", t));
        end

        // pixels after a finished frame are ignored
        drive_pixels(0, 0, 0, 80);
        repeat (10) tick();
        check("post_frame_no_output", got, 0);

        // restart mid-frame: the aborted prefix must not leak into results
        push_exp(vecs[0]);
        pulse_start();
        drive_pixels(1, 0, 0, 40);
        pulse_start();
        drive_pixels(0, 0, 0, W * H);
        finish_frame("abort");

        // async reset mid-frame while a result is being presented
        push_exp(vecs[0]);
        pulse_start();
        drive_pixels(0, 0, 0, 500);
        for (int k = 500; k < 600 && !final_result_valid; k++) drive_pixels(0, 0, k, 1);
        check("valid_before_reset", int'(final_result_valid), 1);
        rst = 0;
        #1;
        check("midreset_valid", int'(final_result_valid), 0);
        check("midreset_done", int'(final_done_signal), 0);
        check("midreset_out", int'(final_result_out), 0);
        repeat (3) tick();
        rst = 1;
        exp_q.delete();
        got = 0;
        dones = 0;
        last_val = 0;
        tick();
        push_exp(vecs[0]);
        pulse_start();
        drive_pixels(0, 0, 0, W * H);
        finish_frame("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/feature_extractor.md
FEATURE_EXTRACTOR -- requirements
Module: feature_extractor

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 32, input image width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT, default 32, input image height in pixels.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start_signal, input, 1, one-cycle pulse that begins a frame.
REQ-006 SHALL have port pixel_valid_in, input, 1, qualifies pixel_in on the current edge.
REQ-007 SHALL have port pixel_in, input, 8, unsigned pixel in raster order (row-major, x fastest).
REQ-008 SHALL have port final_result_out, output, 22 signed, pooled feature value.
REQ-009 SHALL have port final_result_valid, output, 1, final_result_out valid this cycle.
REQ-010 SHALL have port final_done_signal, output, 1, one-cycle end-of-frame pulse.

Function
REQ-011 SHALL accept pixels only while a frame is active: from the cycle after start_signal until IMG_WIDTH*IMG_HEIGHT pixels are accepted; pixel_valid_in outside a frame is ignored.
REQ-012 SHALL tolerate arbitrary idle cycles (pixel_valid_in=0) between pixels with no change in results.
REQ-013 SHALL compute a valid (no padding) 3x3 convolution with kernel rows {1,0,-1},{2,0,-2},{1,0,-1}, pixels zero-extended to signed, producing a (W-2)x(H-2) map (30x30 at default).
REQ-014 SHALL use two line buffers of IMG_WIDTH x 8 bits plus a 3x3 window; a conv output exists once row>=2 and col>=2.
REQ-015 SHALL apply ReLU (negative -> 0) to each conv value, subject to REQ-027.
REQ-016 SHALL 2x2 max-pool, stride 2, over the conv map, discarding an odd trailing row/column; default gives 15x15 = 225 results.
REQ-017 SHALL emit pooled results in raster order (pool row, then pool column), one per final_result_valid cycle.
REQ-018 SHALL hold each pending even-row pooled partial maximum in a row buffer of (W-2)/2 entries of 22 bits.
REQ-019 SHALL assert final_result_valid no more than 4 cycles after the pixel completing that 2x2 window is accepted.
REQ-020 SHALL pulse final_done_signal for exactly one cycle, one cycle after the last (225th) final_result_valid, never coincident with a valid.
REQ-021 SHALL hold final_result_out at its last value when final_result_valid is low.
REQ-022 SHALL, on start_signal during an active frame, abort that frame, discard partial state, and restart counting at pixel 0.
REQ-023 SHALL keep all arithmetic in 22-bit signed; no saturation needed (|conv| <= 1020).

Reset
REQ-024 SHALL, on rst low, immediately clear final_result_out=0, final_result_valid=0, final_done_signal=0, all counters, and the frame-active flag.
REQ-025 SHALL, on reset mid-frame, drop the frame; the next start_signal begins a clean frame.
REQ-026 SHALL not require line-buffer contents to be cleared by reset.

Configuration
REQ-027 SHALL honour macro FEATURE_EXTRACTOR_RELU_EN: defined -> ReLU applied before pooling; undefined -> raw signed conv values are pooled (signed max); result count and timing identical.

Verification (FEATURE_EXTRACTOR_RELU_EN defined)
REQ-028 SHALL cover: pixel = 100+(x XOR y), contiguous valid -> exactly 225 results, all equal to a software Sobel-x/ReLU/2x2-max model, then one done pulse.
REQ-029 SHALL cover: constant image 128 -> 225 results all 0.
REQ-030 SHALL cover: pixel = 255-8x -> 225 results all 64; pixel = 8x -> all 0.
REQ-031 SHALL cover: columns 0-15 = 255, 16-31 = 0 -> result[i] = 1020 when i mod 15 = 7, else 0.
REQ-032 SHALL cover: XOR image with one idle cycle after every pixel -> results identical to REQ-028.
REQ-033 SHALL cover: rst low after 500 pixels -> valid/done drop to 0 at once; subsequent full XOR frame -> REQ-028 results.
